// File: rtl/avst_crdt_mc_counter.sv
// Multi-channel credit counter for the receive side of an AVST credit link.
// Runs the INIT/INIT_ACK handshake, accumulates per-channel credits and grants local consumption.
module avst_crdt_mc_counter #(
  parameter int unsigned CHANNELS         = 2,
  parameter int unsigned UPDATE_CNT_WIDTH = 2,
  parameter int unsigned CNT_WIDTH        = 12,
  parameter int unsigned CONSUME_WIDTH    = 4,
  parameter bit          INFINITE_EN      = 1'b1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_init,
  output logic                                 o_init_ack,
  input  logic [CHANNELS-1:0]                  i_update,
  input  logic [CHANNELS*UPDATE_CNT_WIDTH-1:0] i_update_cnt,
  input  logic [CHANNELS-1:0]                  i_consume_vld,
  input  logic [CHANNELS*CONSUME_WIDTH-1:0]    i_consume_cnt,
  output logic [CHANNELS-1:0]                  o_consume_rdy_c,
  output logic [CHANNELS*CNT_WIDTH-1:0]        o_crdt_avail,
  output logic [CHANNELS-1:0]                  o_crdt_inf,
  output logic                                 o_link_ready,
  output logic [CHANNELS-1:0]                  o_overflow
);

  localparam int unsigned IN_W  = (UPDATE_CNT_WIDTH > CONSUME_WIDTH) ? UPDATE_CNT_WIDTH : CONSUME_WIDTH;
  localparam int unsigned SUM_W = ((CNT_WIDTH > IN_W) ? CNT_WIDTH : IN_W) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_WIDTH{1'b1}});

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INIT = 2'd1,
    S_ACK  = 2'd2,
    S_RUN  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_init_ack_nxt;
  logic   w_link_ready_nxt;
  logic   r_init_ack;
  logic   r_link_ready;

  logic [CHANNELS-1:0][UPDATE_CNT_WIDTH-1:0] w_upd_cnt;
  logic [CHANNELS-1:0][CONSUME_WIDTH-1:0]    w_con_cnt;
  logic [CHANNELS-1:0][SUM_W-1:0]            w_sum;
  logic [CHANNELS-1:0]                       w_grant;
  logic                                      w_enter_init;

  logic [CHANNELS-1:0][CNT_WIDTH-1:0] r_cnt;
  logic [CHANNELS-1:0][CNT_WIDTH-1:0] w_cnt_nxt;
  logic [CHANNELS-1:0]                r_inf;
  logic [CHANNELS-1:0]                w_inf_nxt;
  logic [CHANNELS-1:0]                r_ovf;
  logic [CHANNELS-1:0]                w_ovf_nxt;
  logic [CHANNELS-1:0]                r_seen;
  logic [CHANNELS-1:0]                w_seen_nxt;

  assign w_upd_cnt = i_update_cnt;
  assign w_con_cnt = i_consume_cnt;

  // Handshake state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_init_ack   <= 1'b0;
      r_link_ready <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_init_ack   <= w_init_ack_nxt;
      r_link_ready <= w_link_ready_nxt;
    end
  end

  // Next state; the status flags are registered from the state being entered
  always_comb begin
    w_state_nxt      = r_state;
    w_init_ack_nxt   = 1'b0;
    w_link_ready_nxt = 1'b0;
    case (r_state)
      S_IDLE:  if (i_init) w_state_nxt = S_INIT;
      S_INIT:  if (!i_init) w_state_nxt = S_ACK;
      S_ACK:   w_state_nxt = S_RUN;
      S_RUN:   if (i_init) w_state_nxt = S_INIT;
      default: w_state_nxt = S_IDLE;
    endcase
    w_init_ack_nxt   = (w_state_nxt == S_ACK);
    w_link_ready_nxt = (w_state_nxt == S_RUN);
  end

  // Per-channel grant and counter update; grant sees only the registered count
  always_comb begin
    w_enter_init = (w_state_nxt == S_INIT) && (r_state != S_INIT);
    w_cnt_nxt    = r_cnt;
    w_inf_nxt    = r_inf;
    w_ovf_nxt    = r_ovf;
    w_seen_nxt   = r_seen;
    w_grant      = '0;
    w_sum        = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      w_grant[c] = (r_state == S_RUN) && i_consume_vld[c] &&
                   (r_inf[c] || (SUM_W'(r_cnt[c]) >= SUM_W'(w_con_cnt[c])));
      w_sum[c]   = SUM_W'(r_cnt[c])
                 + (i_update[c] ? SUM_W'(w_upd_cnt[c]) : SUM_W'(0))
                 - (w_grant[c]  ? SUM_W'(w_con_cnt[c]) : SUM_W'(0));
      if (w_enter_init) begin
        w_cnt_nxt[c]  = '0;
        w_inf_nxt[c]  = 1'b0;
        w_ovf_nxt[c]  = 1'b0;
        w_seen_nxt[c] = 1'b0;
      end else if (r_state != S_IDLE) begin
        if (r_inf[c]) begin
          w_cnt_nxt[c] = '0;
        end else if (w_sum[c] > CNT_MAX) begin
          w_cnt_nxt[c] = CNT_WIDTH'(CNT_MAX);
          w_ovf_nxt[c] = 1'b1;
        end else begin
          w_cnt_nxt[c] = CNT_WIDTH'(w_sum[c]);
        end
        if ((r_state == S_INIT) && i_update[c]) begin
          w_seen_nxt[c] = 1'b1;
        end
        // A channel the partner never updated during init runs with unlimited credit
        if ((r_state == S_ACK) && INFINITE_EN && !r_seen[c]) begin
          w_inf_nxt[c] = 1'b1;
          w_cnt_nxt[c] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_inf  <= '0;
      r_ovf  <= '0;
      r_seen <= '0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_inf  <= w_inf_nxt;
      r_ovf  <= w_ovf_nxt;
      r_seen <= w_seen_nxt;
    end
  end

  assign o_init_ack      = r_init_ack;
  assign o_link_ready    = r_link_ready;
  assign o_consume_rdy_c = w_grant;
  assign o_crdt_avail    = r_cnt;
  assign o_crdt_inf      = r_inf;
  assign o_overflow      = r_ovf;

endmodule

// File: doc/avst_crdt_mc_counter.md
# avst_crdt_mc_counter

Multi-channel credit counter for the receiving end of an AVST credit control link. It acknowledges the partner's INIT/INIT_ACK handshake and accumulates credits announced via per-channel UPDATE/UPDATE_CNT. It grants credit consumption to the local transmit logic. It generalises the single credit bus to CHANNELS independent credit types (e.g. header/data), with saturating counters and optional infinite-credit mode.

## Interface
- CHANNELS, 2, number of independent credit types
- UPDATE_CNT_WIDTH, 2, width of one channel's UPDATE_CNT field
- CNT_WIDTH, 12, width of each credit counter; max value 2^CNT_WIDTH-1
- CONSUME_WIDTH, 4, width of one channel's CONSUME_CNT field
- INFINITE_EN, 1, enables infinite-credit detection at init

- CLK  in  1  clock
- RESET_N  in  1  reset, asynchronous, active-low
- INIT  in  1  credit init request from partner
- INIT_ACK  out  1  init acknowledge to partner
- UPDATE  in  CHANNELS  per-channel credit update strobe
- UPDATE_CNT  in  CHANNELS*UPDATE_CNT_WIDTH  credits returned, channel c at [c*W +: W]
- CONSUME_VLD  in  CHANNELS  local request to spend credits
- CONSUME_CNT  in  CHANNELS*CONSUME_WIDTH  credits requested per channel
- CONSUME_RDY  out  CHANNELS  request granted this cycle
- CRDT_AVAIL  out  CHANNELS*CNT_WIDTH  registered counter values
- CRDT_INF  out  CHANNELS  channel is in infinite-credit mode
- LINK_READY  out  1  FSM in RUN
- OVERFLOW  out  CHANNELS  sticky: an update saturated the counter

## Operation
- FSM states: IDLE, INIT, ACK, RUN. Reset state IDLE.
- IDLE: INIT=1 -> INIT. UPDATE ignored.
- INIT: counters, CRDT_INF, OVERFLOW cleared on entry. UPDATE adds UPDATE_CNT to the counter. Per channel, a seen-update flag is set on any UPDATE. INIT=0 -> ACK.
- ACK: INIT_ACK=1 for exactly this one cycle. UPDATE still adds. If INFINITE_EN and a channel's seen-update flag is 0, its CRDT_INF is set. Unconditional -> RUN.
- RUN: LINK_READY=1. UPDATE adds. Consumption is enabled. INIT=1 -> INIT (re-init; counters cleared next cycle, LINK_READY drops).
- CONSUME_RDY[c] = RUN && CONSUME_VLD[c] && (CRDT_INF[c] || CRDT_AVAIL[c] >= CONSUME_CNT[c]). This is combinational from registered state and inputs. Channels are independent; there is no partial grant.
- Counter next value = cnt + (UPDATE ? UPDATE_CNT : 0) - (granted ? CONSUME_CNT : 0). The add and subtract are computed in CNT_WIDTH+1 bits.
  - Result above max clamps to max and sets OVERFLOW[c].
  - Grant is checked against the current count only; a same-cycle update is not bypassed into the check.
- Infinite channels: the counter is held at 0 and updates are ignored (OVERFLOW not set). Grants are always given in RUN.
- CONSUME_CNT=0 with VLD: always granted in RUN; the counter is unchanged.

## Timing
- Reset values: INIT_ACK=0, CONSUME_RDY=0, CRDT_AVAIL=0, CRDT_INF=0, LINK_READY=0, OVERFLOW=0, FSM=IDLE.
- RESET_N low at any time, including mid-RUN, clears everything immediately. A subsequent INIT starts a fresh handshake.
- INIT sampled high at edge n -> INIT state at n+1.
- INIT sampled low in INIT at edge m -> INIT_ACK high during cycle m+1 -> LINK_READY high from m+2.
- UPDATE/consume at edge n -> CRDT_AVAIL reflects it after edge n (visible cycle n+1).
- An INIT pulse of a single cycle is valid: it gives INIT for 1 cycle, then ACK, then RUN.
- INIT re-asserted during ACK is ignored. It is re-detected in RUN the next cycle.

## Test plan
- Basic init: CHANNELS=2, INIT high 4 cycles with UPDATE[0]=1/CNT=3 twice and UPDATE[1]=1/CNT=2 once, then low -> INIT_ACK one cycle, LINK_READY next, CRDT_AVAIL={2,6}, CRDT_INF=0.
- Infinite: INFINITE_EN=1, init with updates only on ch0 -> CRDT_INF=2'b10. CONSUME_CNT[1]=15 is granted repeatedly while CRDT_AVAIL[1] stays 0.
- Grant boundary: ch0 holds 5. Request 6 -> RDY=0, count stays 5. Request 5 -> RDY=1, count 0. Same-cycle UPDATE CNT=3 plus request 5 at count 5 -> granted, result 3.
- Saturation: CNT_WIDTH=4, count 14, UPDATE CNT=3 -> CRDT_AVAIL=15, OVERFLOW[0]=1 and sticky until next INIT.
- Re-init: in RUN with counts {7,4}, INIT=1 -> LINK_READY=0, counts 0, OVERFLOW cleared. Consume requests during re-init give RDY=0. A new handshake completes normally.
- Async reset: RESET_N low mid-RUN between clock edges -> all outputs 0 without waiting for a clock edge. State remains IDLE until INIT.
